// File: rtl/sram_mp_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mp_ctrl
//  Description : Multi-port asynchronous SRAM controller. Arbitrates between
//                NPORTS requesters (round-robin or fixed priority) and runs
//                one SETUP / ACCESS(WAIT) / FINISH strobe sequence per grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mp_ctrl #(
    parameter int NPORTS = 2,
    parameter int AW     = 18,
    parameter int DW     = 16,
    parameter int WAIT   = 1,
    parameter int RR     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NPORTS-1:0]          i_req,
    input  logic [NPORTS-1:0]          i_we,
    input  logic [NPORTS*AW-1:0]       i_addr,
    input  logic [NPORTS*DW-1:0]       i_wdata,
    output logic [NPORTS-1:0]          o_done,
    output logic [DW-1:0]              o_rdata,
    output logic [$clog2(NPORTS)-1:0]  o_grant_id,
    output logic                       o_busy,
    output logic [AW-1:0]              o_sram_addr,
    inout  wire  [DW-1:0]              io_sram_data,
    output logic                       o_sram_en_n,
    output logic                       o_sram_oe_n,
    output logic                       o_sram_we_n
);

    localparam int c_IW = $clog2(NPORTS);
    // One extra bit so the rotated search index can exceed NPORTS-1 before wrap
    localparam int c_JW = c_IW + 1;
    localparam logic [c_JW-1:0] c_NP = c_JW'(NPORTS);
    // WAIT of 0 behaves as 1; counter compares against the last ACCESS cycle
    localparam logic [3:0] c_WAIT_LAST = (WAIT <= 1) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_nxt_state;

    logic [c_IW-1:0]     r_ptr;
    logic [c_IW-1:0]     r_idx;
    logic                r_we;
    logic [DW-1:0]       r_wdata;
    logic [AW-1:0]       r_sram_addr;
    logic [3:0]          r_cnt;
    logic                r_en_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_drive;
    logic [NPORTS-1:0]   r_done;
    logic [DW-1:0]       r_rdata;

    logic [c_IW-1:0]     w_win;
    logic                w_any;
    logic [c_JW-1:0]     w_j;
    logic                w_nxt_en_n;
    logic                w_nxt_oe_n;
    logic                w_nxt_we_n;
    logic                w_nxt_drive;
    logic                w_nxt_done;

    // Pick the winning requester: rotate from last grant + 1, or scan from port 0
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        w_j   = '0;
        for (int k = 0; k < NPORTS; k++) begin
            if (RR != 0) begin
                w_j = {1'b0, r_ptr} + c_JW'(k + 1);
                if (w_j >= c_NP) begin
                    w_j = w_j - c_NP;
                end
            end else begin
                w_j = c_JW'(k);
            end
            if (!w_any && i_req[w_j[c_IW-1:0]]) begin
                w_any = 1'b1;
                w_win = w_j[c_IW-1:0];
            end
        end
    end

    // Next state plus the strobe levels that go with the state being entered
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_en_n  = 1'b1;
        w_nxt_oe_n  = 1'b1;
        w_nxt_we_n  = 1'b1;
        w_nxt_drive = 1'b0;
        w_nxt_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_nxt_state = S_SETUP;
                    w_nxt_en_n  = 1'b0;
                    w_nxt_drive = i_we[w_win];
                end
            end
            S_SETUP: begin
                w_nxt_state = S_ACCESS;
                w_nxt_en_n  = 1'b0;
                w_nxt_oe_n  = r_we;
                w_nxt_we_n  = ~r_we;
                w_nxt_drive = r_we;
            end
            S_ACCESS: begin
                w_nxt_en_n  = 1'b0;
                w_nxt_drive = r_we;
                if (r_cnt == c_WAIT_LAST) begin
                    // we_n rises here while data keeps being driven for hold time
                    w_nxt_state = S_FINISH;
                    w_nxt_done  = 1'b1;
                end else begin
                    w_nxt_oe_n = r_we;
                    w_nxt_we_n = ~r_we;
                end
            end
            S_FINISH: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Grant latch, wait counter, registered SRAM strobes, done pulse and read capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr       <= c_IW'(NPORTS - 1);
            r_idx       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
            r_cnt       <= 4'd0;
            r_en_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_done      <= '0;
            r_rdata     <= '0;
        end else begin
            r_en_n  <= w_nxt_en_n;
            r_oe_n  <= w_nxt_oe_n;
            r_we_n  <= w_nxt_we_n;
            r_drive <= w_nxt_drive;

            r_done <= '0;
            if (w_nxt_done) begin
                r_done[r_idx] <= 1'b1;
            end

            if (r_state == S_IDLE && w_any) begin
                r_idx       <= w_win;
                r_ptr       <= w_win;
                r_we        <= i_we[w_win];
                r_sram_addr <= i_addr[w_win*AW +: AW];
                r_wdata     <= i_wdata[w_win*DW +: DW];
            end

            if (r_state == S_SETUP) begin
                r_cnt <= 4'd0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
            end

            if (r_state == S_ACCESS && w_nxt_state == S_FINISH && !r_we) begin
                r_rdata <= io_sram_data;
            end
        end
    end

    assign io_sram_data = r_drive ? r_wdata : {DW{1'bz}};
    assign o_done       = r_done;
    assign o_rdata      = r_rdata;
    assign o_grant_id   = r_idx;
    assign o_busy       = (r_state != S_IDLE);
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_en_n  = r_en_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_we_n  = r_we_n;

endmodule
`default_nettype wire
